// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b physical-memory arbiter: line/word types and the
// arbiter state encoding, which doubles as the externally visible grant.
package mem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_I    = 2'b01,
    ARB_D    = 2'b10
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the caches plus pmem.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic          i_mem_read;
  lc3b_word      i_mem_address;
  lc3b_line      i_mem_rdata;
  logic          i_mem_resp;

  logic          d_mem_read;
  logic          d_mem_write;
  lc3b_word      d_mem_address;
  lc3b_line      d_mem_wdata;
  lc3b_line      d_mem_rdata;
  logic          d_mem_resp;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_line      pmem_wdata;
  lc3b_line      pmem_rdata;
  logic          pmem_resp;

  lc3b_arb_state grant;

  modport slave (
    input  i_mem_read, i_mem_address,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_mem_rdata, i_mem_resp,
    output d_mem_rdata, d_mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output grant
  );

  modport master (
    output i_mem_read, i_mem_address,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_mem_rdata, i_mem_resp,
    input  d_mem_rdata, d_mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  grant
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating up-counter with synchronous clear; counts D grants that were
// made while fetch was left waiting.
module arb_starve_counter #(
  parameter  int LIMIT = 4,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single pmem line port between I-cache and D-cache misses.
// D has priority; a starvation counter forces an I grant after STARVE_LIMIT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  mem_arbiter_if.slave   bus
);

  localparam int            CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  lc3b_arb_state state, state_next;
  lc3b_word      addr_q;
  lc3b_line      wdata_q;
  logic          wr_q;
  logic          d_req, i_req;
  logic          starve_inc, starve_clr, starve_ok;
  logic [CW-1:0] starve_count;

  assign d_req     = bus.d_mem_read | bus.d_mem_write;
  assign i_req     = bus.i_mem_read;
  assign starve_ok = (starve_count < LIM);

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .count (starve_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (d_req && (starve_ok || !i_req)) begin
          state_next = ARB_D;
          starve_inc = i_req;
        end else if (i_req) begin
          state_next = ARB_I;
          starve_clr = 1'b1;
        end
      end
      ARB_I, ARB_D: begin
        if (bus.pmem_resp) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Grant latch: pmem sees only these registers, so a requester changing
  // its inputs mid-transaction cannot disturb the bus. Read+write resolves
  // as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (state == ARB_IDLE) begin
      unique case (state_next)
        ARB_D: begin
          addr_q  <= bus.d_mem_address;
          wdata_q <= bus.d_mem_wdata;
          wr_q    <= bus.d_mem_write;
        end
        ARB_I: begin
          addr_q <= bus.i_mem_address;
          wr_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_read    = (state != ARB_IDLE) && !wr_q;
  assign bus.pmem_write   = (state != ARB_IDLE) &&  wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign bus.i_mem_resp   = (state == ARB_I) && bus.pmem_resp;
  assign bus.d_mem_resp   = (state == ARB_D) && bus.pmem_resp;
  assign bus.i_mem_rdata  = bus.pmem_rdata;
  assign bus.d_mem_rdata  = bus.pmem_rdata;
  assign bus.grant        = state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port physical-memory arbiter for the LC-3b pipeline. It shares the single 128-bit physical-memory port between instruction-cache and data-cache miss traffic. D-cache requests have priority; a starvation counter bounds how long fetch can be locked out. It sits between the two caches and `pmem`, below the fetch and mem/writeback stages.

## Interface
- `STARVE_LIMIT`, default 4: consecutive D grants made while I is waiting before I is forced to win.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_mem_read` in 1: I-cache line-read request; held until `i_mem_resp`.
- `i_mem_address` in 16: I-cache line address.
- `i_mem_rdata` out 128: line data to the I-cache (`pmem_rdata` broadcast).
- `i_mem_resp` out 1: one-cycle completion pulse to the I-cache.
- `d_mem_read` in 1: D-cache line-read request.
- `d_mem_write` in 1: D-cache line-writeback request.
- `d_mem_address` in 16: D-cache line address.
- `d_mem_wdata` in 128: D-cache writeback line.
- `d_mem_rdata` out 128: line data to the D-cache (`pmem_rdata` broadcast).
- `d_mem_resp` out 1: one-cycle completion pulse to the D-cache.
- `pmem_read`, `pmem_write` out 1 each: physical-memory strobes.
- `pmem_address` out 16: latched address.
- `pmem_wdata` out 128: latched write line.
- `pmem_rdata` in 128: physical-memory read data.
- `pmem_resp` in 1: physical-memory completion.
- `grant` out 2: current owner (`ARB_IDLE`/`ARB_I`/`ARB_D`) for debug and perf counters.

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`.
- Leaving `IDLE`:
  - D request pending (`d_mem_read|d_mem_write`) and starve count < `STARVE_LIMIT`, or no I request → `SERVE_D`.
  - Otherwise, if I request pending → `SERVE_I`.
  - Otherwise stay in `IDLE`.
- Grant latch: on the `IDLE`→`SERVE_x` edge, latch address, wdata and op (read/write) into internal registers. `pmem_*` outputs come only from these registers and the state, never combinationally from requester inputs.
- D read and write asserted together is a protocol error. It is resolved as a write.
- `SERVE_x`:
  - Drive `pmem_read`/`pmem_write` from the latched op until `pmem_resp`.
  - On the `pmem_resp` cycle, pulse `x_mem_resp` (combinational from `pmem_resp` and state) and return to `IDLE` next edge.
- `i_mem_rdata` and `d_mem_rdata` both equal `pmem_rdata` at all times. Only the resp pulse qualifies the data.
- Starve counter (width `$clog2(STARVE_LIMIT+1)`):
  - +1 on each `IDLE`→`SERVE_D` while `i_mem_read` is high; saturates at `STARVE_LIMIT`.
  - Cleared on `IDLE`→`SERVE_I`.
  - Unchanged otherwise.
- Requester drops its request mid-transaction: illegal. The arbiter completes the `pmem` transaction and still pulses resp to the latched owner.
- `pmem_resp` arriving in `IDLE` is ignored; no resp pulse.

## Timing
- Reset values (async, while `rst_n`=0):
  - state `IDLE`, counter 0.
  - `pmem_read`=`pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0.
  - `i_mem_resp`=`d_mem_resp`=0, `grant`=`ARB_IDLE`.
- Request sampled at edge N (in `IDLE`) → `pmem` strobe high from after edge N. With `pmem_resp` at cycle N+k, requester resp is in the same cycle.
- Back-to-back: one mandatory `IDLE` bubble cycle between transactions; the next grant is decided in that bubble.
- Minimum service time is 2 cycles: grant, then resp at the earliest.
- Simultaneous I and D requests in `IDLE`: D wins unless counter = `STARVE_LIMIT`.
- Reset asserted mid-transaction: strobes drop immediately. The `pmem` transaction is abandoned; `pmem` must also be reset.

## Structure
- In `lc3b_types`:
  - `lc3b_arb_state` enum (`ARB_IDLE`=2'b00, `ARB_I`=2'b01, `ARB_D`=2'b10), which also encodes `grant`.
  - `lc3b_line` typedef (128-bit).
- `lc3b_word` is used for addresses.
- One sub-module: `arb_starve_counter` (saturating up-counter with clear). All other logic is inline.

## Test plan
- Single I read, addr 0x1230, `pmem_resp` 3 cycles after strobe → `pmem_read`=1 with addr 0x1230; `i_mem_resp` one pulse; `d_mem_resp` stays 0; `grant` goes `ARB_I` then `ARB_IDLE`.
- D write (addr 0x4000, wdata 0xDEAD…BEEF) and I read raised in the same cycle → D served first with `pmem_write`=1. After resp, one `IDLE` cycle, then I is served.
- D request continuously re-raised while I waits, `STARVE_LIMIT`=4 → 4 D grants, then I granted; counter returns to 0.
- D changes `d_mem_address` 0x4000→0x5000 mid-transaction → `pmem_address` holds 0x4000 until resp.
- `rst_n` pulled low mid-`SERVE_D` → all strobes 0 asynchronously; after release, `grant`=`ARB_IDLE` and a pending I request is served next.
- `d_mem_read` and `d_mem_write` both high → `pmem_write`=1, `pmem_read`=0; `pmem_resp` in `IDLE` → no resp pulses.
